// File: rtl/ppu_vga_pkg.sv
// rtl/ppu_vga_pkg.sv - VGA 640x480@60 timing constants and NES palette for the PPU scaler
//
// Contents:
//   H_*/V_*      horizontal/vertical timing (visible, front porch, sync, back porch, totals)
//   NES_W/IMG_W  NES line width and its 2x-scaled width on the VGA raster
//   NES_PALETTE  64-entry palette, 24-bit 0xRRGGBB
//   pal_to_rgb   6-bit palette index -> 24-bit RGB
package ppu_vga_pkg;

  // Horizontal timing in pixel ticks.
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;

  // Vertical timing in lines.
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;

  localparam int NES_W = 256;
  localparam int IMG_W = 2 * NES_W;

  localparam logic [23:0] NES_PALETTE [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

  function automatic logic [23:0] pal_to_rgb(input logic [5:0] idx);
    return NES_PALETTE[idx];
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel-tick divider and 800x525 VGA raster counters
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   tick          one-clk strobe every CLK_DIV clocks; all raster state moves on it
//   hc, vc        horizontal (0..799) and vertical (0..524) counters
//   hsync_raw_n   undelayed horizontal sync, active low
//   vsync_raw_n   undelayed vertical sync, active low
//   active        hc/vc inside the 640x480 visible area
module vga_timing
  import ppu_vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync_raw_n,
  output logic       vsync_raw_n,
  output logic       active
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;

  // With div starting at 0 the first tick lands CLK_DIV clocks after reset release.
  assign tick = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (tick) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  assign hsync_raw_n = !((hc >= H_SYNC_START) && (hc < H_SYNC_END));
  assign vsync_raw_n = !((vc >= V_SYNC_START) && (vc < V_SYNC_END));
  assign active      = (hc < H_VISIBLE) && (vc < V_VISIBLE);

endmodule

// File: rtl/ppu_vga_scaler.sv
// rtl/ppu_vga_scaler.sv - NES scanline capture and 2x2 upscale onto 640x480@60 VGA
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   pix_we, pix_x, pix_idx  PPU pixel write: palette index pix_idx at column pix_x
//   line_done               PPU finished a visible scanline; swaps the ping-pong buffers
//   hsync_n, vsync_n        VGA syncs, active low
//   vga_r, vga_g, vga_b     8-bit colour channels
//   blank                   high outside the 640x480 active area
//
// Build option: define SCANLINE_DIM_EN to halve RGB on odd VGA lines.
module ppu_vga_scaler
  import ppu_vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_BORDER = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_we,
  input  logic [7:0] pix_x,
  input  logic [5:0] pix_idx,
  input  logic       line_done,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       blank
);

  localparam logic [9:0] IMG_START = 10'(H_BORDER);
  localparam logic [9:0] IMG_END   = 10'(H_BORDER + IMG_W);

  // ---------------------------------------------------------------- raster
  logic       tick;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       hsync_raw_n;
  logic       vsync_raw_n;
  logic       active;

  vga_timing #(
    .CLK_DIV (CLK_DIV)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .hc          (hc),
    .vc          (vc),
    .hsync_raw_n (hsync_raw_n),
    .vsync_raw_n (vsync_raw_n),
    .active      (active)
  );

  // ---------------------------------------------------------------- line buffers
  logic [5:0] line_mem [2][NES_W];
  logic       wr_sel;
  logic       rd_sel;
  logic       line_valid;

  // Contents are deliberately not reset; line_valid keeps stale data off the pins.
  always_ff @(posedge clk) begin
    if (pix_we) begin
      line_mem[wr_sel][pix_x] <= pix_idx;
    end
  end

  // A write coinciding with line_done still uses the old wr_sel above, so it
  // lands in the line that is just being completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel     <= 1'b0;
      line_valid <= 1'b0;
    end else if (line_done) begin
      wr_sel     <= ~wr_sel;
      line_valid <= 1'b1;
    end
  end

  // The display buffer is chosen once per VGA line pair so both copies of an
  // NES line come from the same buffer even if the PPU swaps mid-pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel <= 1'b1;
    end else if (tick && (hc == 10'd0) && !vc[0]) begin
      rd_sel <= ~wr_sel;
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic [9:0] img_col;
  logic       in_img;

  assign img_col = hc - IMG_START;
  assign in_img  = active && (hc >= IMG_START) && (hc < IMG_END);

  logic [7:0] s1_addr;
  logic       s1_show;
  logic       s1_hsync_n;
  logic       s1_vsync_n;
  logic       s1_blank;
`ifdef SCANLINE_DIM_EN
  logic       s1_odd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_addr    <= '0;
      s1_show    <= 1'b0;
      s1_hsync_n <= 1'b1;
      s1_vsync_n <= 1'b1;
      s1_blank   <= 1'b1;
`ifdef SCANLINE_DIM_EN
      s1_odd     <= 1'b0;
`endif
    end else if (tick) begin
      // Each NES column covers two VGA columns, hence the drop of bit 0.
      s1_addr    <= img_col[8:1];
      s1_show    <= in_img && line_valid;
      s1_hsync_n <= hsync_raw_n;
      s1_vsync_n <= vsync_raw_n;
      s1_blank   <= !active;
`ifdef SCANLINE_DIM_EN
      s1_odd     <= vc[0];
`endif
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [23:0] base_rgb;
  logic [23:0] pix_rgb;

  always_comb begin
    base_rgb = 24'h000000;
    if (s1_show) begin
      base_rgb = pal_to_rgb(line_mem[rd_sel][s1_addr]);
    end
  end

  always_comb begin
    pix_rgb = base_rgb;
`ifdef SCANLINE_DIM_EN
    if (s1_odd) begin
      pix_rgb = {1'b0, base_rgb[23:17], 1'b0, base_rgb[15:9], 1'b0, base_rgb[7:1]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      blank   <= 1'b1;
      vga_r   <= '0;
      vga_g   <= '0;
      vga_b   <= '0;
    end else if (tick) begin
      hsync_n <= s1_hsync_n;
      vsync_n <= s1_vsync_n;
      blank   <= s1_blank;
      vga_r   <= pix_rgb[23:16];
      vga_g   <= pix_rgb[15:8];
      vga_b   <= pix_rgb[7:0];
    end
  end

  // Upper vc bits only matter to the timing block; the outer img_col bits are
  // outside the 512-column window whenever in_img is true.
  logic unused_bits;
  assign unused_bits = ^{vc[9:1], img_col[9], img_col[0]};

endmodule
